// File: rtl/ring_renderer.sv
// Two-stage ring/disc pixel renderer with double-buffered configuration.
// Optional pulse animation (breathing radius) is built when RING_PULSE_EN is defined.
module ring_renderer #(
    parameter int          WIDTH    = 96,
    parameter int          HEIGHT   = 64,
    parameter logic [15:0] BG_COLOR = 16'h0000,
    parameter int          R_MAX    = 31
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic [12:0] pixel_index,
    input  logic        frame_tick,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [6:0]  cfg_cx,
    input  logic [5:0]  cfg_cy,
    input  logic [5:0]  cfg_r_in,
    input  logic [5:0]  cfg_r_out,
    input  logic [15:0] cfg_color,
    input  logic        cfg_pulse,
    output logic [15:0] color
);

    typedef struct packed {
        logic [6:0]  cx;
        logic [5:0]  cy;
        logic [5:0]  r_in;
        logic [5:0]  r_out;
        logic [15:0] color;
    } ring_cfg_t;

    typedef enum logic {IDLE, PENDING} state_t;

    localparam ring_cfg_t  CFG_RST = '{cx: 7'(WIDTH / 2), cy: 6'(HEIGHT / 2),
                                       r_in: 6'd12, r_out: 6'd14, color: 16'hFFFF};
    localparam logic [12:0] NPIX   = 13'(WIDTH * HEIGHT);
    localparam logic [6:0]  RMAX7  = 7'(R_MAX);

    state_t    state, state_nxt;
    ring_cfg_t shadow, act;
    logic      capture, apply;
    logic [5:0] off;

    // ---------------- configuration handshake FSM ----------------
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        capture   = 1'b0;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                // a simultaneous frame_tick is deliberately not used to apply
                if (cfg_valid) begin
                    capture   = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (frame_tick) begin
                    apply     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            shadow <= CFG_RST;
            act    <= CFG_RST;
        end else begin
            if (capture) shadow <= '{cx: cfg_cx, cy: cfg_cy, r_in: cfg_r_in,
                                     r_out: cfg_r_out, color: cfg_color};
            if (apply)   act    <= shadow;
        end
    end

    // ---------------- pulse animation ----------------
`ifdef RING_PULSE_EN
    typedef enum logic {GROW, SHRINK} dir_t;

    dir_t dir;
    logic pulse_sh, pulse_act;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            off       <= '0;
            dir       <= GROW;
            pulse_sh  <= 1'b0;
            pulse_act <= 1'b0;
        end else begin
            if (capture) pulse_sh <= cfg_pulse;
            if (apply) begin
                pulse_act <= pulse_sh;
                off       <= '0;
                dir       <= GROW;
            end else if (frame_tick && pulse_act) begin
                if ({1'b0, act.r_out} >= RMAX7) begin
                    off <= '0;
                end else if (dir == GROW) begin
                    off <= off + 6'd1;
                    // turn around once the next outer radius would hit R_MAX
                    if ({1'b0, act.r_out} + {1'b0, off} + 7'd2 >= RMAX7) dir <= SHRINK;
                end else if (off <= 6'd1) begin
                    off <= '0;
                    dir <= GROW;
                end else begin
                    off <= off - 6'd1;
                end
            end
        end
    end
`else
    logic unused_pulse;
    assign unused_pulse = cfg_pulse;
    assign off          = '0;
`endif

    // ---------------- stage 1: centre-relative coordinates ----------------
    logic [7:0]        x8, y8;
    logic signed [7:0] dx_q, dy_q;
    logic              in_q;

    assign x8 = 8'(pixel_index % 13'(WIDTH));
    assign y8 = 8'(pixel_index / 13'(WIDTH));

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            dx_q <= '0;
            dy_q <= '0;
            in_q <= 1'b0;
        end else begin
            dx_q <= x8 - {1'b0, act.cx};
            dy_q <= y8 - {2'b0, act.cy};
            in_q <= pixel_index < NPIX;
        end
    end

    // ---------------- stage 2: distance test and colour ----------------
    logic signed [15:0] dx_w, dy_w, sq_x, sq_y;
    logic [15:0]        d2;
    logic [6:0]         lo, hi;
    logic [13:0]        lo2, hi2;
    logic               hit;

    assign dx_w = {{8{dx_q[7]}}, dx_q};
    assign dy_w = {{8{dy_q[7]}}, dy_q};
    assign sq_x = dx_w * dx_w;
    assign sq_y = dy_w * dy_w;
    assign d2   = $unsigned(sq_x) + $unsigned(sq_y);

    // 7-bit radii so radius+offset never wraps; r_in > r_out yields an empty band
    assign lo  = {1'b0, act.r_in}  + {1'b0, off};
    assign hi  = {1'b0, act.r_out} + {1'b0, off};
    assign lo2 = {7'd0, lo} * {7'd0, lo};
    assign hi2 = {7'd0, hi} * {7'd0, hi};
    assign hit = in_q && ({2'b0, lo2} <= d2) && (d2 <= {2'b0, hi2});

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) color <= BG_COLOR;
        else       color <= hit ? act.color : BG_COLOR;
    end

endmodule

// File: tb/tb_ring_renderer.sv
// Scoreboard bench for ring_renderer: stimulus pushes expected pixels, a monitor
// pops them two clocks later; also checks handshake and reset behaviour.
module tb_ring_renderer;

    logic        clk25 = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] pixel_index = '0;
    logic        frame_tick = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [6:0]  cfg_cx = '0;
    logic [5:0]  cfg_cy = '0;
    logic [5:0]  cfg_r_in = '0;
    logic [5:0]  cfg_r_out = '0;
    logic [15:0] cfg_color = '0;
    logic        cfg_pulse = 1'b0;
    logic [15:0] color;

    ring_renderer dut (
        .clk25(clk25), .reset(reset), .pixel_index(pixel_index), .frame_tick(frame_tick),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cx(cfg_cx), .cfg_cy(cfg_cy),
        .cfg_r_in(cfg_r_in), .cfg_r_out(cfg_r_out), .cfg_color(cfg_color),
        .cfg_pulse(cfg_pulse), .color(color)
    );

    always #20 clk25 = ~clk25;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] q[$];
    int          qi[$];
    logic        drive_vld = 1'b0;
    logic [1:0]  vpipe = '0;

    // reference model state
    int m_cx = 48, m_cy = 32, m_rin = 12, m_rout = 14, m_off = 0;
    logic [15:0] m_col = 16'hFFFF;

`ifdef RING_PULSE_EN
    int offs[5] = '{1, 2, 1, 0, 1};
`else
    int offs[5] = '{0, 0, 0, 0, 0};
`endif

    function automatic logic [15:0] model(input int idx);
        int x, y, dx, dy, d2, lo, hi;
        if (idx >= 96 * 64) return 16'h0000;
        x = idx % 96; y = idx / 96;
        dx = x - m_cx; dy = y - m_cy;
        d2 = dx * dx + dy * dy;
        lo = m_rin + m_off; hi = m_rout + m_off;
        return (lo * lo <= d2 && d2 <= hi * hi) ? m_col : 16'h0000;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk25) vpipe <= {vpipe[0], drive_vld};

    always @(negedge clk25) begin
        if (vpipe[1]) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL pix: output with empty scoreboard, got %0h", color);
            end else begin
                logic [15:0] e;
                int          ix;
                e = q.pop_front();
                ix = qi.pop_front();
                if (color !== e) begin
                    n_err++;
                    $display("FAIL pix[%0d]: got %h expected %h", ix, color, e);
                end
            end
        end
    end

    task automatic put(input int idx, input logic [15:0] exp);
        @(negedge clk25);
        pixel_index = 13'(idx);
        drive_vld   = 1'b1;
        q.push_back(exp);
        qi.push_back(idx);
    endtask

    task automatic scan(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) put(i, model(i));
    endtask

    task automatic settle();
        @(negedge clk25);
        drive_vld = 1'b0;
        repeat (3) @(negedge clk25);
    endtask

    task automatic tick();
        @(negedge clk25);
        drive_vld  = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk25);
        frame_tick = 1'b0;
    endtask

    task automatic offer(input int cx, input int cy, input int ri, input int ro,
                         input logic [15:0] col, input logic pulse, input logic with_tick);
        @(negedge clk25);
        drive_vld  = 1'b0;
        cfg_cx     = 7'(cx);  cfg_cy    = 6'(cy);
        cfg_r_in   = 6'(ri);  cfg_r_out = 6'(ro);
        cfg_color  = col;     cfg_pulse = pulse;
        cfg_valid  = 1'b1;
        frame_tick = with_tick;
        @(negedge clk25);
        cfg_valid  = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk25);
        chk("rst_color", color, 16'h0000);
        chk("rst_ready", cfg_ready, 1);
        reset = 1'b0;

        // default ring about (48,32), r 12..14
        put(3132, 16'hFFFF);   // (60,32) d2=144
        put(3134, 16'hFFFF);   // (62,32) d2=196
        put(3135, 16'h0000);   // (63,32) d2=225
        put(4272, 16'hFFFF);   // (48,44) d2=144
        put(3072 + 48, 16'h0000);
        scan(0, 6143);
        settle();

        // red disc: captured, held pending until the next frame_tick
        offer(10, 10, 0, 3, 16'hF800, 1'b0, 1'b0);
        chk("pend_ready", cfg_ready, 0);
        put(3132, 16'hFFFF);
        put(970, 16'h0000);
        settle();
        offer(20, 20, 0, 9, 16'h001F, 1'b0, 1'b0);  // ignored while pending
        chk("pend_ready2", cfg_ready, 0);
        put(3132, 16'hFFFF);
        settle();
        tick();
        chk("apply_ready", cfg_ready, 1);
        m_cx = 10; m_cy = 10; m_rin = 0; m_rout = 3; m_col = 16'hF800;
        put(970, 16'hF800);    // centre, d2=0
        put(973, 16'hF800);    // d2=9
        put(974, 16'h0000);    // d2=16
        put(1164, 16'hF800);   // (12,12) d2=8
        put(3132, 16'h0000);
        scan(0, 6143);
        settle();

        // cfg_valid together with frame_tick: capture only
        offer(80, 50, 2, 6, 16'h07E0, 1'b0, 1'b1);
        chk("cotick_ready", cfg_ready, 0);
        put(970, 16'hF800);
        put(4883, 16'h0000);
        settle();
        tick();
        chk("cotick_apply_ready", cfg_ready, 1);
        m_cx = 80; m_cy = 50; m_rin = 2; m_rout = 6; m_col = 16'h07E0;
        put(4880, 16'h0000);   // d2=0 inside inner radius
        put(4883, 16'h07E0);   // d2=9
        put(4886, 16'h07E0);   // d2=36
        put(4887, 16'h0000);   // d2=49
        scan(0, 6143);
        settle();

        // inverted radii: empty band everywhere, out-of-range index too
        offer(48, 32, 5, 4, 16'hFFFF, 1'b0, 1'b0);
        tick();
        m_cx = 48; m_cy = 32; m_rin = 5; m_rout = 4; m_col = 16'hFFFF;
        scan(0, 6143);
        put(6200, 16'h0000);
        put(3072 + 52, 16'h0000);
        settle();

        // out-of-range index that would otherwise fall inside the disc
        offer(56, 63, 0, 3, 16'h07E0, 1'b0, 1'b0);
        tick();
        m_cx = 56; m_cy = 63; m_rin = 0; m_rout = 3; m_col = 16'h07E0;
        put(6104, 16'h07E0);   // (56,63)
        put(6008, 16'h07E0);   // (56,62)
        put(6200, 16'h0000);   // would be (56,64)
        put(6143, 16'h0000);
        settle();

        // pulse: apply tick does not step, then successive ticks
        offer(48, 32, 20, 28, 16'hFFFF, 1'b1, 1'b0);
        tick();
        m_cx = 48; m_cy = 32; m_rin = 20; m_rout = 28; m_col = 16'hFFFF; m_off = 0;
        scan(3072, 3167);
        settle();
        for (int k = 0; k < 5; k++) begin
            tick();
            m_off = offs[k];
            scan(3072, 3167);
            settle();
        end

        // pulse with r_out at R_MAX: offset stays 0
        offer(48, 32, 25, 31, 16'hFFFF, 1'b1, 1'b0);
        tick();
        m_rin = 25; m_rout = 31; m_off = 0;
        tick();
        tick();
        put(3072 + 79, 16'hFFFF);
        put(3072 + 80, 16'h0000);
        scan(3072, 3167);
        settle();

        // reset while pending discards the shadow config
        offer(10, 10, 0, 3, 16'hF800, 1'b0, 1'b0);
        chk("pend_ready3", cfg_ready, 0);
        @(negedge clk25);
        reset = 1'b1;
        #1;
        chk("rst_pend_ready", cfg_ready, 1);
        chk("rst_pend_color", color, 16'h0000);
        repeat (2) @(negedge clk25);
        reset = 1'b0;
        m_cx = 48; m_cy = 32; m_rin = 12; m_rout = 14; m_col = 16'hFFFF; m_off = 0;
        tick();
        chk("post_rst_ready", cfg_ready, 1);
        put(970, 16'h0000);
        put(3132, 16'hFFFF);
        scan(0, 6143);
        settle();

        chk("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
